quadrature_decoder: RTL

Upstream front end for the encoder path. Samples raw A/B/Z encoder pins on csi_MCLK_clk, synchronises and glitch-filters them, and performs x4 quadrature decoding into a signed 32-bit position with direction, index and illegal-transition tracking. Results are exposed on an Avalon-MM slave and as direct outputs for downstream position consumers.

---
 rtl/quadrature_decoder_if.sv | 25 ++
 rtl/quadrature_decoder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/quadrature_decoder_if.sv
// Avalon-MM control port bundle for quadrature_decoder.
// Transfer rules: waitrequest is always 0, so a write or read strobe held for
// one clock is one complete transfer; read data appears on readdata the clock
// after the read strobe and holds until the next read.
interface quadrature_decoder_if;
    logic [31:0] avs_ctrl_writedata;
    logic [31:0] avs_ctrl_readdata;
    logic [3:0]  avs_ctrl_byteenable;
    logic [2:0]  avs_ctrl_address;
    logic        avs_ctrl_write;
    logic        avs_ctrl_read;
    logic        avs_ctrl_waitrequest;

    modport master (
        output avs_ctrl_writedata, avs_ctrl_byteenable, avs_ctrl_address,
        output avs_ctrl_write, avs_ctrl_read,
        input  avs_ctrl_readdata, avs_ctrl_waitrequest
    );

    modport slave (
        input  avs_ctrl_writedata, avs_ctrl_byteenable, avs_ctrl_address,
        input  avs_ctrl_write, avs_ctrl_read,
        output avs_ctrl_readdata, avs_ctrl_waitrequest
    );
endinterface

// File: rtl/quadrature_decoder.sv
// Quadrature encoder front end: synchronise and glitch-filter A/B/Z, x4 decode
// into a signed 32-bit position, track direction, index and illegal steps.
// Optional index latch / clear-on-index enabled by defining QDEC_INDEX_LATCH_EN.
module quadrature_decoder #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [7:0]  FILT_RST    = 8'd3,
    parameter logic [31:0] ID_VALUE    = 32'hEA680004
) (
    input  logic                 csi_MCLK_clk,
    input  logic                 rsi_MRST_reset,
    quadrature_decoder_if.slave  avs,
    input  logic                 A,
    input  logic                 B,
    input  logic                 Z,
    output logic [31:0]          pos_count,
    output logic                 pos_dir,
    output logic                 index_pulse
);
    // Boot sequence: filters follow the synced pins directly until the
    // synchroniser has flushed, then prev state is seeded, then decoding runs.
    localparam logic [7:0] BOOT_DONE = 8'(SYNC_STAGES + 2);

    logic [2:0]  r_sync [SYNC_STAGES];   // bit 2 = A, bit 1 = B, bit 0 = Z
    logic [2:0]  r_filt;
    logic [7:0]  r_fcnt [3];
    logic [7:0]  r_boot;
    logic [1:0]  r_prev;
    logic        r_z_prev;
    logic [31:0] r_pos;
    logic        r_dir;
    logic        r_idx_pulse;
    logic        r_idx;
    logic        r_err;
    logic [7:0]  r_err_cnt;
    logic        r_en;
    logic [7:0]  r_filt_len;
    logic [31:0] r_rdata;

    logic [2:0]  w_sync;
    logic        w_bypass, w_run;
    logic        w_wr_pos, w_wr_stat, w_wr_ctrl, w_filt_restart;
    logic        w_fwd, w_rev, w_ill;
    logic        w_step_fwd, w_step_rev, w_z_rise, w_idx_clr;
    logic        w_clr_idx_w1c, w_clr_err_w1c;
    logic        w_clr_on_idx;
    logic [31:0] w_idx_latch;
    logic [31:0] w_pos_merged;
    logic [31:0] w_rd_mux;

    assign w_sync         = r_sync[SYNC_STAGES-1];
    assign w_bypass       = (r_boot <= 8'(SYNC_STAGES));
    assign w_run          = (r_boot == BOOT_DONE);
    assign w_wr_pos       = avs.avs_ctrl_write && (avs.avs_ctrl_address == 3'd1);
    assign w_wr_stat      = avs.avs_ctrl_write && (avs.avs_ctrl_address == 3'd2);
    assign w_wr_ctrl      = avs.avs_ctrl_write && (avs.avs_ctrl_address == 3'd3);
    assign w_filt_restart = w_wr_ctrl && (avs.avs_ctrl_byteenable[0] || avs.avs_ctrl_byteenable[1]);
    assign w_clr_idx_w1c  = w_wr_stat && avs.avs_ctrl_byteenable[0] && avs.avs_ctrl_writedata[1];
    assign w_clr_err_w1c  = w_wr_stat && avs.avs_ctrl_byteenable[0] && avs.avs_ctrl_writedata[2];
    assign w_step_fwd     = w_run && r_en && w_fwd;
    assign w_step_rev     = w_run && r_en && w_rev;
    assign w_z_rise       = w_run && r_filt[0] && !r_z_prev;
    assign w_idx_clr      = w_z_rise && w_clr_on_idx;

    // Count clocks after reset release until decoding is allowed to run.
    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset)        r_boot <= '0;
        else if (r_boot != BOOT_DONE) r_boot <= r_boot + 8'd1;
    end

    // Multi-flop synchroniser for the asynchronous encoder pins.
    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
        end else begin
            r_sync[0] <= {A, B, Z};
            for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
        end
    end

    // Per-pin filter: output follows only after FILT+1 consecutive mismatching clocks.
    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            r_filt <= '0;
            for (int p = 0; p < 3; p++) r_fcnt[p] <= '0;
        end else begin
            for (int p = 0; p < 3; p++) begin
                if (w_bypass) begin
                    r_filt[p] <= w_sync[p];
                    r_fcnt[p] <= '0;
                end else if (w_filt_restart || (w_sync[p] == r_filt[p])) begin
                    r_fcnt[p] <= '0;
                end else if (r_fcnt[p] >= r_filt_len) begin
                    r_filt[p] <= w_sync[p];
                    r_fcnt[p] <= '0;
                end else begin
                    r_fcnt[p] <= r_fcnt[p] + 8'd1;
                end
            end
        end
    end

    // Classify the prev -> current filtered {A,B} transition.
    always_comb begin
        w_fwd = 1'b0;
        w_rev = 1'b0;
        w_ill = 1'b0;
        case ({r_prev, r_filt[2:1]})
            4'b0001, 4'b0111, 4'b1110, 4'b1000: w_fwd = 1'b1;
            4'b0010, 4'b1011, 4'b1101, 4'b0100: w_rev = 1'b1;
            4'b0011, 4'b1100, 4'b0110, 4'b1001: w_ill = w_run;
            default: ;
        endcase
    end

    // Track previous filtered A/B and Z every clock, independent of EN.
    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            r_prev   <= '0;
            r_z_prev <= 1'b0;
        end else begin
            r_prev   <= r_filt[2:1];
            r_z_prev <= r_filt[0];
        end
    end

    // Byte-wise merge of a bus write into the current position.
    always_comb begin
        w_pos_merged = r_pos;
        for (int b = 0; b < 4; b++) begin
            if (avs.avs_ctrl_byteenable[b]) w_pos_merged[8*b +: 8] = avs.avs_ctrl_writedata[8*b +: 8];
        end
    end

    // Position and direction: bus write beats clear-on-index beats a step.
    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            r_pos <= '0;
            r_dir <= 1'b0;
        end else begin
            if (w_wr_pos)        r_pos <= w_pos_merged;
            else if (w_idx_clr)  r_pos <= '0;
            else if (w_step_fwd) r_pos <= r_pos + 32'd1;
            else if (w_step_rev) r_pos <= r_pos - 32'd1;
            if (w_step_fwd)      r_dir <= 1'b1;
            else if (w_step_rev) r_dir <= 1'b0;
        end
    end

    // Sticky status flags; a new set event wins over a same-cycle W1C.
    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            r_idx_pulse <= 1'b0;
            r_idx       <= 1'b0;
            r_err       <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            r_idx_pulse <= w_z_rise;
            if (w_z_rise)           r_idx <= 1'b1;
            else if (w_clr_idx_w1c) r_idx <= 1'b0;
            if (w_ill)              r_err <= 1'b1;
            else if (w_clr_err_w1c) r_err <= 1'b0;
            if (w_clr_err_w1c)      r_err_cnt <= w_ill ? 8'd1 : 8'd0;
            else if (w_ill && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

`ifdef QDEC_INDEX_LATCH_EN
    logic        r_clr_on_idx;
    logic [31:0] r_idx_latch;
    assign w_clr_on_idx = r_clr_on_idx;
    assign w_idx_latch  = r_idx_latch;

    // Clear-on-index enable and the pre-step position captured at each index.
    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            r_clr_on_idx <= 1'b0;
            r_idx_latch  <= '0;
        end else begin
            if (w_wr_ctrl && avs.avs_ctrl_byteenable[0]) r_clr_on_idx <= avs.avs_ctrl_writedata[1];
            if (w_z_rise) r_idx_latch <= r_pos;
        end
    end
`else
    assign w_clr_on_idx = 1'b0;
    assign w_idx_latch  = '0;
`endif

    // Control register fields, honouring byte enables.
    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            r_en       <= 1'b1;
            r_filt_len <= FILT_RST;
        end else if (w_wr_ctrl) begin
            if (avs.avs_ctrl_byteenable[0]) begin
                r_en            <= avs.avs_ctrl_writedata[0];
                r_filt_len[3:0] <= avs.avs_ctrl_writedata[7:4];
            end
            if (avs.avs_ctrl_byteenable[1]) r_filt_len[7:4] <= avs.avs_ctrl_writedata[11:8];
        end
    end

    // Read data selection by word address.
    always_comb begin
        w_rd_mux = '0;
        case (avs.avs_ctrl_address)
            3'd0: w_rd_mux = ID_VALUE;
            3'd1: w_rd_mux = r_pos;
            3'd2: w_rd_mux = {16'd0, r_err_cnt, 5'd0, r_err, r_idx, r_dir};
            3'd3: w_rd_mux = {20'd0, r_filt_len, 2'd0, w_clr_on_idx, r_en};
            3'd4: w_rd_mux = w_idx_latch;
            default: w_rd_mux = '0;
        endcase
    end

    // Registered read data, updated only on a read strobe.
    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset)         r_rdata <= '0;
        else if (avs.avs_ctrl_read) r_rdata <= w_rd_mux;
    end

    assign avs.avs_ctrl_readdata    = r_rdata;
    assign avs.avs_ctrl_waitrequest = 1'b0;
    assign pos_count                = r_pos;
    assign pos_dir                  = r_dir;
    assign index_pulse              = r_idx_pulse;
endmodule
